hdr_green_merge: RTL and testbench



---
 rtl/hdr_pkg.sv | 13 +
 rtl/hdr_hat_weight.sv | 9 +
 rtl/hdr_green_merge.sv | 102 ++++++++++
 tb/tb_hdr_green_merge.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdr_pkg.sv
// hdr_pkg: shared widths and the hat weighting function for the HDR merge blocks
package hdr_pkg;
    localparam int PIX_G_W = 6;
    localparam int G_W = 8;
    localparam int W_W = 5;
    localparam int LNDT_W_DEF = 10;

    function automatic logic [7:0] hat_weight(input logic [7:0] z, input int pix_w);
        logic [7:0] m;
        m = 8'((1 << pix_w) - 1);
        return (z <= m - z) ? z : m - z;
    endfunction
endpackage

// File: rtl/hdr_hat_weight.sv
// hdr_hat_weight: combinational hat weight min(Z, 2^PIX_W-1-Z), shared by all colour merges
module hdr_hat_weight import hdr_pkg::*; #(
    parameter int PIX_W = PIX_G_W
) (
    input  logic [PIX_W-1:0] pixel,
    output logic [PIX_W-2:0] weight
);
    assign weight = (PIX_W - 1)'(hat_weight(8'(pixel), PIX_W));
endmodule

// File: rtl/hdr_green_merge.sv
// hdr_green_merge: Debevec weighted merge of NUM_EXP green exposures into num/den sums
module hdr_green_merge import hdr_pkg::*; #(
    parameter int NUM_EXP = 3,
    parameter int LNDT_W = LNDT_W_DEF,
    parameter int NUM_W = 18,
    parameter int DEN_W = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_EXP*LNDT_W-1:0] ln_dt,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic [PIX_G_W-1:0]        in_pixel,
    output logic [PIX_G_W-1:0]        lut_pixel,
    output logic                      lut_clk_en,
    input  logic [G_W-1:0]            lut_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [NUM_W-1:0]   out_num,
    output logic [DEN_W-1:0]          out_den,
    output logic                      out_zero_w,
    output logic                      err_sync
);
    localparam int KW = $clog2(NUM_EXP);
    localparam int TERM_W = (LNDT_W > G_W ? LNDT_W : G_W + 1) + 1;
    localparam int PROD_W = TERM_W + W_W;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_EXP - 1);

    if (NUM_W < PROD_W + $clog2(NUM_EXP)) begin : g_num_w_check
        $error("NUM_W too narrow for the accumulated products");
    end

    logic en, take;
    logic [KW-1:0] cnt, k, s1_k;
    logic [W_W-1:0] w, s1_w;
    logic s1_valid, s1_last;
    logic signed [LNDT_W-1:0] ldt;
    logic signed [TERM_W-1:0] term;
    logic signed [PROD_W-1:0] prod;
    logic signed [NUM_W-1:0] acc_num, sum_num;
    logic [DEN_W-1:0] acc_den, sum_den;

    hdr_hat_weight #(.PIX_W(PIX_G_W)) u_weight (.pixel(in_pixel), .weight(w));

    assign en = !(out_valid && !out_ready);
    assign take = in_valid && en;
    assign in_ready = en;
    assign lut_clk_en = en;
    assign lut_pixel = in_pixel;
    // A mid-pixel in_first restarts the pixel at exposure 0
    assign k = in_first ? '0 : cnt;

    always_comb begin
        ldt = ln_dt[s1_k*LNDT_W +: LNDT_W];
        term = TERM_W'($signed({1'b0, lut_data})) - TERM_W'(ldt);
        prod = PROD_W'(term) * PROD_W'($signed({1'b0, s1_w}));
        sum_num = ((s1_k == '0) ? '0 : acc_num) + NUM_W'(prod);
        sum_den = ((s1_k == '0) ? '0 : acc_den) + DEN_W'(s1_w);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            err_sync <= 1'b0;
            s1_valid <= 1'b0;
            s1_w <= '0;
            s1_k <= '0;
            s1_last <= 1'b0;
            acc_num <= '0;
            acc_den <= '0;
            out_valid <= 1'b0;
            out_num <= '0;
            out_den <= '0;
            out_zero_w <= 1'b0;
        end else begin
            if (take) begin
                cnt <= (k == K_LAST) ? '0 : k + 1'b1;
                err_sync <= err_sync || (in_first && cnt != '0);
            end
            if (en) begin
                s1_valid <= take;
                if (take) begin
                    s1_w <= w;
                    s1_k <= k;
                    s1_last <= (k == K_LAST);
                end
                // lut_data is only meaningful behind a valid stage-1 sample
                if (s1_valid) begin
                    acc_num <= s1_last ? '0 : sum_num;
                    acc_den <= s1_last ? '0 : sum_den;
                    if (s1_last) begin
                        out_num <= sum_num;
                        out_den <= sum_den;
                        out_zero_w <= (sum_den == '0);
                    end
                end
            end
            out_valid <= (en && s1_valid && s1_last) || (out_valid && !out_ready);
        end
    end
endmodule

// File: tb/tb_hdr_green_merge.sv
// tb_hdr_green_merge: randomized and directed checks of hdr_green_merge against a sum-of-terms model
module tb_hdr_green_merge;
    localparam int NE = 3;
    localparam int LW = 10;
    localparam int NW = 18;
    localparam int DW = 7;

    typedef struct {int num; int den;} res_t;

    logic clk = 0;
    logic rst_n = 0;
    logic [NE*LW-1:0] ln_dt = {10'd32, 10'd16, 10'd0};
    logic in_valid = 0, in_first = 0, out_ready = 1;
    logic [5:0] in_pixel = 0;
    logic in_ready, lut_clk_en, out_valid, out_zero_w, err_sync;
    logic [5:0] lut_pixel;
    logic [7:0] lut_data;
    logic signed [NW-1:0] out_num;
    logic [DW-1:0] out_den;

    int ldt [NE] = '{0, 16, 32};
    logic [7:0] g_tab [64];
    int total = 0, bad = 0, cyc = 0;
    res_t exp_q[$];
    int t_q[$];
    int m_cnt = 0, m_num = 0, m_den = 0;
    bit m_err = 0;
    bit stim_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (lut_clk_en) lut_data <= g_tab[lut_pixel];

    hdr_green_merge #(.NUM_EXP(NE), .LNDT_W(LW), .NUM_W(NW), .DEN_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .ln_dt(ln_dt), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_pixel(in_pixel), .lut_pixel(lut_pixel), .lut_clk_en(lut_clk_en),
        .lut_data(lut_data), .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num),
        .out_den(out_den), .out_zero_w(out_zero_w), .err_sync(err_sync)
    );

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int hw(int z);
        return z < 32 ? z : 63 - z;
    endfunction

    // Reference: each completed pixel is sum over its samples of w(Z)*(g(Z)-ln_dt[k]) and w(Z)
    always @(negedge clk) begin : mon
        int k, z;
        res_t e;
        if (!rst_n) begin
            m_cnt = 0;
            m_err = 0;
        end else begin
            check("err_sync", err_sync, m_err);
            if (out_valid && out_ready) begin
                t_q.push_back(cyc);
                if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("num", $signed(out_num), e.num);
                    check("den", out_den, e.den);
                    check("zero_w", out_zero_w, e.den == 0);
                end
            end
            if (in_valid && in_ready) begin
                z = in_pixel;
                if (in_first && m_cnt != 0) m_err = 1;
                k = in_first ? 0 : m_cnt;
                if (k == 0) begin
                    m_num = 0;
                    m_den = 0;
                end
                m_num += hw(z) * (int'(g_tab[z]) - ldt[k]);
                m_den += hw(z);
                if (k == NE - 1) begin
                    exp_q.push_back('{m_num, m_den});
                    m_cnt = 0;
                end else m_cnt = k + 1;
            end
        end
    end

    task automatic send(input int z, input logic f);
        int n = 0;
        in_valid = 1;
        in_pixel = 6'(z);
        in_first = f;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        in_first = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pixel(input int a, input int b, input int c);
        send(a, 1);
        send(b, 0);
        send(c, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) g_tab[i] = 8'($urandom_range(0, 255));
        g_tab[32] = 45;
        g_tab[16] = 31;
        g_tab[8] = 22;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_num", out_num, 0);
        check("rst_out_den", out_den, 0);
        check("rst_zero_w", out_zero_w, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        pixel(6'h20, 6'h10, 6'h08);
        @(negedge clk);
        check("lat_early", out_valid, 0);
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        check("dir_num", $signed(out_num), 1555);
        check("dir_den", out_den, 55);
        check("dir_zero", out_zero_w, 0);
        idle(2);

        pixel(6'h00, 6'h3F, 6'h00);
        @(negedge clk);
        @(negedge clk);
        check("zero_valid", out_valid, 1);
        check("zero_num", out_num, 0);
        check("zero_den", out_den, 0);
        check("zero_flag", out_zero_w, 1);
        idle(2);

        fork
            for (int p = 0; p < 4; p++) pixel($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
            begin
                for (int n = 0; n < 100 && !out_valid; n++) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_clk_en", lut_clk_en, 0);
                    check("stall_valid", out_valid, 1);
                end
                @(posedge clk);
                #1 out_ready = 1;
            end
        join
        idle(4);
        check("stall_drained", exp_q.size(), 0);

        t_q.delete();
        for (int p = 0; p < 4; p++) pixel($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
        idle(4);
        check("b2b_count", t_q.size(), 4);
        for (int i = 1; i < t_q.size(); i++) check("b2b_gap", t_q[i] - t_q[i-1], NE);

        send(5, 1);
        send(9, 1);
        send(40, 0);
        send(50, 0);
        pixel(20, 33, 61);
        idle(4);
        check("err_sticky", err_sync, 1);

        send(7, 1);
        rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_num", out_num, 0);
        check("mid_rst_den", out_den, 0);
        check("mid_rst_err", err_sync, 0);
        check("mid_rst_lut_pixel", lut_pixel, in_pixel);
        pixel(12, 30, 45);
        idle(4);

        fork
            begin
                for (int p = 0; p < 40; p++)
                    for (int s = 0; s < NE; s++) begin
                        if ($urandom_range(0, 3) == 0) idle(1);
                        send($urandom_range(0, 63), (s == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0));
                    end
                stim_done = 1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1;
            end
        join

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) idle(1);
        check("final_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
